counter8_down_async_resetb: RTL

Loadable 8-bit down counter with a small run-control FSM, terminal-count pulse and optional auto-reload. It is the counting-down companion to the existing up counters in the simple_registers/counters family. It acts as a programmable interval timer: software-style load/start controls in, a `tc` event out. It is a self-contained micro-benchmark block with no downstream dependencies.

---
 rtl/counter_pkg.sv | 11 +
 rtl/counter8_down_async_resetb.sv | 84 ++++++++
 2 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the simple counter family: default width and run-control FSM states.
package counter_pkg;

    localparam int COUNTER_WIDTH_DEFAULT = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } cnt_state_t;

endpackage

// File: rtl/counter8_down_async_resetb.sv
// Loadable down counter / interval timer with IDLE/RUN control, one-cycle terminal-count pulse
// and optional auto-reload. All outputs come straight from registers.
module counter8_down_async_resetb
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             tc
);

    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    cnt_state_t       state_q, state_d;
    logic             tc_q, tc_d;

    always_comb begin
        result_d = result_q;
        reload_d = reload_q;
        state_d  = state_q;
        tc_d     = 1'b0;
        if (load) begin
            result_d = load_value;
            reload_d = load_value;
            state_d  = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A start on zero is a zero-length interval: report it, never run.
                    if (start) begin
                        if (result_q != '0) state_d = ST_RUN;
                        else                tc_d    = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (enable) begin
                        if (result_q == WIDTH'(1)) begin
                            tc_d = 1'b1;
                            if (auto_reload) begin
                                result_d = reload_q;
                            end else begin
                                result_d = '0;
                                state_d  = ST_IDLE;
                            end
                        end else if (result_q != '0) begin
                            result_d = result_q - WIDTH'(1);
                        end else begin
                            // Unreachable in normal use; never wrap below zero.
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            result_q <= '0;
            reload_q <= '0;
            state_q  <= ST_IDLE;
            tc_q     <= 1'b0;
        end else begin
            result_q <= result_d;
            reload_q <= reload_d;
            state_q  <= state_d;
            tc_q     <= tc_d;
        end
    end

    assign result = result_q;
    assign busy   = (state_q == ST_RUN);
    assign tc     = tc_q;

endmodule
